// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter
//   Two-requester round-robin arbiter in front of a 256x32 DPRAM Avalon-MM slave
//   with no waitrequest, fixed 1-cycle read latency and registered readdatavalid.
//   At most one command reaches the slave per cycle. Read returns come back in
//   order and are steered to the issuing port using a small tag FIFO.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   m0_* / m1_*           requester Avalon-MM ports (address, read, write,
//                         writedata, waitrequest, readdata, readdatavalid)
//   s_*                   slave-side command outputs and read-return inputs
module dpram_rr_arbiter #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int MAX_PENDING = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_read,
   output logic              s_write,
   output logic [DATA_W-1:0] s_writedata,
   input  logic [DATA_W-1:0] s_readdata,
   input  logic              s_readdatavalid
);

   localparam int PTR_W = $clog2(MAX_PENDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

   logic             last_grant;
   logic [CNT_W-1:0] pend_cnt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             tag_mem [MAX_PENDING];

   logic rd_ok;
   logic elig0;
   logic elig1;
   logic grant0;
   logic grant1;
   logic push;
   logic pop;
   logic head_tag;

   // Eligibility looks only at the registered count, so a return popping in
   // this cycle frees its slot for the next cycle, not this one.
   always_comb begin
      rd_ok  = (pend_cnt < CNT_MAX);
      elig0  = m0_write | (m0_read & rd_ok);
      elig1  = m1_write | (m1_read & rd_ok);
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (elig0 && elig1) begin
         grant0 = last_grant;
         grant1 = ~last_grant;
      end else begin
         grant0 = elig0;
         grant1 = elig1;
      end
   end

   assign m0_waitrequest = (m0_read | m0_write) & ~grant0;
   assign m1_waitrequest = (m1_read | m1_write) & ~grant1;

   // Write wins when a port raises read and write together.
   always_comb begin
      s_address   = m0_address;
      s_writedata = m0_writedata;
      s_read      = grant0 & m0_read & ~m0_write;
      s_write     = grant0 & m0_write;
      if (grant1) begin
         s_address   = m1_address;
         s_writedata = m1_writedata;
         s_read      = m1_read & ~m1_write;
         s_write     = m1_write;
      end
   end

   assign push     = s_read;
   // Returns arriving with nothing outstanding are strays (e.g. across reset).
   assign pop      = s_readdatavalid & (pend_cnt != '0);
   assign head_tag = tag_mem[rd_ptr];

   assign m0_readdatavalid = pop & ~head_tag;
   assign m1_readdatavalid = pop & head_tag;
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
         pend_cnt   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         if (grant0 | grant1)
            last_grant <= grant1;
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
            2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
            default: pend_cnt <= pend_cnt;
         endcase
      end
   end

   // Tag storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push)
         tag_mem[wr_ptr] <= grant1;
   end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// tb_dpram_rr_arbiter
//   Directed scenarios followed by randomized traffic. A behavioural slave
//   (memory plus return queue that can be held back) sits behind the arbiter.
//   A reference model (memory array, queue of expected returns, last winner)
//   predicts grants, slave command, and routed returns every cycle.
module tb_dpram_rr_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  m0_address = '0, m1_address = '0;
   logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [31:0] m0_writedata = '0, m1_writedata = '0;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [7:0]  s_address;
   logic        s_read, s_write;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata = '0;
   logic        s_readdatavalid = 1'b0;

   dpram_rr_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_PENDING(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid)
   );

   always #5 clk = ~clk;

   // Slave: 1-cycle registered read return unless held back.
   logic [31:0] slv_mem [256];
   logic [31:0] slv_q [$];
   logic        hold = 1'b0;

   always @(posedge clk) begin
      if (s_write)
         slv_mem[s_address] <= s_writedata;
      if (s_read)
         slv_q.push_back(slv_mem[s_address]);
      if (!hold && slv_q.size() > 0) begin
         s_readdata      <= slv_q.pop_front();
         s_readdatavalid <= 1'b1;
      end else begin
         s_readdatavalid <= 1'b0;
      end
   end

   // Reference model
   typedef struct {
      bit          port;
      logic [31:0] data;
   } ret_t;

   ret_t        exp_q [$];
   logic [31:0] mem_model [256];
   bit          model_lg = 1'b1;
   bit          acc0, acc1;
   logic        smp_w0, smp_w1;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      model_lg = 1'b1;
   endtask

   // One clock cycle: check combinational outputs at the negedge, then
   // advance the model at the posedge. Returns 1 time unit after the posedge.
   task automatic step();
      bit   e0, e1, g0, g1, rdv, have;
      ret_t h;
      logic [31:0] wd;
      logic [7:0]  ad;
      @(negedge clk);
      e0 = m0_write || (m0_read && exp_q.size() < 4);
      e1 = m1_write || (m1_read && exp_q.size() < 4);
      if (e0 && e1) begin
         g0 = model_lg;
         g1 = !model_lg;
      end else begin
         g0 = e0;
         g1 = e1;
      end
      smp_w0 = m0_waitrequest;
      smp_w1 = m1_waitrequest;
      chk("m0_wait", 64'(m0_waitrequest), 64'((m0_read || m0_write) && !g0));
      chk("m1_wait", 64'(m1_waitrequest), 64'((m1_read || m1_write) && !g1));
      chk("s_read",  64'(s_read),  64'((g0 && m0_read && !m0_write) || (g1 && m1_read && !m1_write)));
      chk("s_write", 64'(s_write), 64'((g0 && m0_write) || (g1 && m1_write)));
      ad = g1 ? m1_address : m0_address;
      wd = g1 ? m1_writedata : m0_writedata;
      chk("s_address", 64'(s_address), 64'(ad));
      chk("s_writedata", 64'(s_writedata), 64'(wd));
      rdv  = s_readdatavalid;
      have = rdv && exp_q.size() > 0;
      h.port = 1'b0;
      h.data = '0;
      if (have)
         h = exp_q[0];
      chk("m0_rdv", 64'(m0_readdatavalid), 64'(have && !h.port));
      chk("m1_rdv", 64'(m1_readdatavalid), 64'(have && h.port));
      if (have)
         chk("rdata", h.port ? 64'(m1_readdata) : 64'(m0_readdata), 64'(h.data));
      acc0 = g0;
      acc1 = g1;
      @(posedge clk);
      if (reset_n) begin
         if (have)
            void'(exp_q.pop_front());
         if (g0 || g1) begin
            if (g1 ? m1_write : m0_write)
               mem_model[ad] = wd;
            else
               exp_q.push_back('{port: g1, data: mem_model[ad]});
            model_lg = g1;
         end
      end
      #1;
   endtask

   task automatic idle();
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int r;
      for (int i = 0; i < 256; i++) begin
         slv_mem[i]   = '0;
         mem_model[i] = '0;
      end
      model_reset();
      step(); step();
      reset_n = 1'b1;
      step();

      // Contending reads after reset: m0 first, then alternate.
      m0_read = 1'b1; m0_address = 8'h01;
      m1_read = 1'b1; m1_address = 8'h02;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_m0_wait", 64'(smp_w0), 64'(i % 2));
         chk("t2_m1_wait", 64'(smp_w1), 64'((i + 1) % 2));
         chk("t2_ret_m0", 64'(m0_readdatavalid), 64'(i % 2 == 0));
         chk("t2_ret_m1", 64'(m1_readdatavalid), 64'(i % 2 == 1));
      end
      idle();
      step(); step();

      // Write then read back on m0.
      m0_write = 1'b1; m0_address = 8'h10; m0_writedata = 32'hDEADBEEF;
      step();
      m0_write = 1'b0; m0_read = 1'b1;
      step();
      chk("t1_m0_rdv", 64'(m0_readdatavalid), 64'd1);
      chk("t1_m0_data", 64'(m0_readdata), 64'hDEADBEEF);
      chk("t1_m1_rdv", 64'(m1_readdatavalid), 64'd0);
      idle();
      step();

      // Outstanding limit with held returns; m0 writes still get through.
      hold = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         m1_read = 1'b1; m1_address = 8'(8'h40 + n);
         if (i >= 4) begin
            m0_write = 1'b1; m0_address = 8'h50; m0_writedata = 32'(32'hA5A5 + i);
         end
         step();
         if (acc1) n++;
         if (i >= 4) begin
            chk("t3_m1_stall", 64'(smp_w1), 64'd1);
            chk("t3_m0_wr_ok", 64'(smp_w0), 64'd0);
         end
      end
      m0_write = 1'b0;
      hold = 1'b0;
      m1_address = 8'(8'h40 + n);
      step();
      chk("t3_still_full", 64'(smp_w1), 64'd1);
      step();
      chk("t3_no_early_slot", 64'(smp_w1), 64'd1);
      step();
      chk("t3_slot_freed", 64'(smp_w1), 64'd0);
      idle();
      for (int i = 0; i < 8; i++) step();

      // Reset with two reads outstanding; stale returns must be dropped.
      hold = 1'b1;
      m0_read = 1'b1; m0_address = 8'h10;
      step();
      m0_read = 1'b0; m1_read = 1'b1; m1_address = 8'h50;
      step();
      idle();
      reset_n = 1'b0;
      model_reset();
      step();
      reset_n = 1'b1;
      hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_m0_stale", 64'(m0_readdatavalid), 64'd0);
         chk("t5_m1_stale", 64'(m1_readdatavalid), 64'd0);
      end

      // m0 write and m1 read of same address in the same cycle.
      m0_write = 1'b1; m0_address = 8'h20; m0_writedata = 32'h1;
      m1_read = 1'b1; m1_address = 8'h20;
      step();
      chk("t4_m0_first", 64'(smp_w0), 64'd0);
      chk("t4_m1_waits", 64'(smp_w1), 64'd1);
      m0_write = 1'b0;
      step();
      chk("t4_m1_accept", 64'(smp_w1), 64'd0);
      chk("t4_m1_rdv", 64'(m1_readdatavalid), 64'd1);
      chk("t4_m1_data", 64'(m1_readdata), 64'h1);
      idle();
      step();

      // Read and write together act as a write.
      m0_read = 1'b1; m0_write = 1'b1; m0_address = 8'h30; m0_writedata = 32'h55;
      step();
      chk("t6_no_read", 64'(s_readdatavalid), 64'd0);
      m0_write = 1'b0;
      step();
      chk("t6_m0_rdv", 64'(m0_readdatavalid), 64'd1);
      chk("t6_m0_data", 64'(m0_readdata), 64'h55);
      idle();
      step();

      // Random traffic; commands held stable while stalled.
      for (int i = 0; i < 400; i++) begin
         if (!(m0_read || m0_write) || acc0) begin
            r = int'($urandom_range(0, 3));
            m0_read = (r == 1 || r == 3); m0_write = (r >= 2);
            m0_address = 8'($urandom_range(0, 15)); m0_writedata = $urandom;
         end
         if (!(m1_read || m1_write) || acc1) begin
            r = int'($urandom_range(0, 3));
            m1_read = (r == 1 || r == 3); m1_write = (r >= 2);
            m1_address = 8'($urandom_range(0, 15)); m1_writedata = $urandom;
         end
         hold = ($urandom_range(0, 3) == 0);
         step();
      end
      idle();
      hold = 1'b0;
      for (int i = 0; i < 10; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
